// File: rtl/fractal_sdf.sv
// Multi-shape signed-distance evaluator: sphere, box or Menger sponge at a
// power-of-two world scale, using one shared multiplier and a bit-serial root.
module fractal_sdf #(
    parameter int WIDTH    = 32,
    parameter int FBITS    = 16,
    parameter int MAX_ITER = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            sdf_start,
    input  logic [1:0]                      mode,
    input  logic [$clog2(MAX_ITER+1)-1:0]   iters,
    input  logic [3:0]                      scale_shift,
    input  logic signed [WIDTH-1:0]         x,
    input  logic signed [WIDTH-1:0]         y,
    input  logic signed [WIDTH-1:0]         z,
    output logic                            busy,
    output logic                            sdf_done,
    output logic signed [WIDTH-1:0]         sdf_out
);
    localparam int IW   = $clog2(MAX_ITER + 1);
    localparam int NS   = (WIDTH + FBITS) / 2;
    localparam int RADW = 2 * NS;
    localparam int RW   = NS + 3;
    localparam int CW   = $clog2(NS + 1);
    localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1 << FBITS);
    localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_BOX_Q, S_SQ0, S_SQ1, S_SQ2, S_SQRT,
        S_BOX_D, S_ITER_A, S_ITER_B, S_ITER_C, S_OUT, S_DONE
    } state_t;

    function automatic logic signed [WIDTH-1:0] smax(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [WIDTH-1:0] smin(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [WIDTH-1:0] sabs(input logic signed [WIDTH-1:0] a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH:0] t;
        t = (WIDTH+1)'(a) + (WIDTH+1)'(b);
        if (t > (WIDTH+1)'(MAXV)) return MAXV;
        if (t < (WIDTH+1)'(MINV)) return MINV;
        return t[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] mult(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] ae, be, pr;
        ae = (2*WIDTH)'(a);
        be = (2*WIDTH)'(b);
        pr = ae * be;
        return WIDTH'(pr >>> FBITS);
    endfunction

    // Folds one axis of the scaled point into the cross distance |1 - 3|a||.
    function automatic logic signed [WIDTH-1:0] fold(input logic [FBITS:0] m);
        logic signed [WIDTH-1:0] a, t;
        a = WIDTH'(m) - ONE;
        a = sabs(a);
        t = ONE - (a + (a <<< 1));
        return sabs(t);
    endfunction

    function automatic int recip_const(input int i);
        int p3;
        p3 = 3;
        for (int j = 0; j < i; j++) p3 = p3 * 3;
        return (1 << FBITS) / p3;
    endfunction

    logic signed [WIDTH-1:0] recip_tab [2**IW];
    for (genvar g = 0; g < 2**IW; g++) begin : g_recip
        assign recip_tab[g] = WIDTH'(recip_const(g));
    end

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic signed [WIDTH-1:0] out_q, out_d;
    logic [1:0]              mode_q, mode_d;
    logic [IW-1:0]           k_q, k_d, it_q, it_d;
    logic [3:0]              shift_q, shift_d;
    logic signed [WIDTH-1:0] px_q, px_d, py_q, py_d, pz_q, pz_d;
    logic signed [WIDTH-1:0] qx_q, qx_d, qy_q, qy_d, qz_q, qz_d;
    logic signed [WIDTH-1:0] sum_q, sum_d, d_q, d_d, m_q, m_d;
    logic signed [WIDTH-1:0] psx_q, psx_d, psy_q, psy_d, psz_q, psz_d;
    logic signed [WIDTH-1:0] rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
    logic [RADW-1:0]         rad_q, rad_d;
    logic [RW-1:0]           rem_q, rem_d;
    logic [NS-1:0]           root_q, root_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic signed [WIDTH-1:0] sq_in, sq_v, mul_a, mul_b, prod, sum_new, root_ext, maxq;
    logic [RW-1:0]           rem_t, trial;
    logic [IW-1:0]           it_inc;

    // Shared multiplier: squares during SQ0..SQ2, reciprocal scaling in ITER_C.
    always_comb begin
        case (state_q)
            S_SQ1:   sq_in = qy_q;
            S_SQ2:   sq_in = qz_q;
            default: sq_in = qx_q;
        endcase
        sq_v  = (mode_q == 2'd0) ? sq_in : smax(sq_in, '0);
        mul_a = (state_q == S_ITER_C) ? (m_q - ONE) : sq_v;
        mul_b = (state_q == S_ITER_C) ? recip_tab[it_q] : sq_v;
    end

    assign prod     = mult(mul_a, mul_b);
    assign sum_new  = sat_add((state_q == S_SQ0) ? '0 : sum_q, prod);
    assign rem_t    = {rem_q[RW-3:0], rad_q[RADW-1 -: 2]};
    assign trial    = RW'({root_q, 2'b01});
    assign root_ext = WIDTH'(root_q);
    assign maxq     = smax(smax(qx_q, qy_q), qz_q);
    assign it_inc   = it_q + 1'b1;

    always_comb begin
        state_d = state_q;  busy_d = busy_q;  done_d = 1'b0;  out_d = out_q;
        mode_d  = mode_q;   k_d = k_q;        it_d = it_q;    shift_d = shift_q;
        px_d  = px_q;   py_d  = py_q;   pz_d  = pz_q;
        qx_d  = qx_q;   qy_d  = qy_q;   qz_d  = qz_q;
        psx_d = psx_q;  psy_d = psy_q;  psz_d = psz_q;
        rx_d  = rx_q;   ry_d  = ry_q;   rz_d  = rz_q;
        sum_d = sum_q;  d_d = d_q;      m_d = m_q;
        rad_d = rad_q;  rem_d = rem_q;  root_d = root_q;  cnt_d = cnt_q;
        case (state_q)
            S_IDLE: begin
                // busy still high here means this is the done-strobe cycle
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (sdf_start) begin
                    mode_d  = mode;
                    shift_d = scale_shift;
                    k_d     = (mode == 2'd2) ? ((iters > IW'(MAX_ITER)) ? IW'(MAX_ITER) : iters) : '0;
                    px_d    = x;
                    py_d    = y;
                    pz_d    = z;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                px_d    = px_q >>> shift_q;
                py_d    = py_q >>> shift_q;
                pz_d    = pz_q >>> shift_q;
                state_d = S_BOX_Q;
            end
            S_BOX_Q: begin
                qx_d    = (mode_q == 2'd0) ? px_q : sabs(px_q) - ONE;
                qy_d    = (mode_q == 2'd0) ? py_q : sabs(py_q) - ONE;
                qz_d    = (mode_q == 2'd0) ? pz_q : sabs(pz_q) - ONE;
                state_d = S_SQ0;
            end
            S_SQ0: begin
                sum_d   = sum_new;
                state_d = S_SQ1;
            end
            S_SQ1: begin
                sum_d   = sum_new;
                state_d = S_SQ2;
            end
            S_SQ2: begin
                rad_d   = RADW'({sum_new, {FBITS{1'b0}}});
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = '0;
                state_d = S_SQRT;
            end
            S_SQRT: begin
                if (rem_t >= trial) begin
                    rem_d  = rem_t - trial;
                    root_d = {root_q[NS-2:0], 1'b1};
                end else begin
                    rem_d  = rem_t;
                    root_d = {root_q[NS-2:0], 1'b0};
                end
                rad_d = rad_q << 2;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NS - 1)) state_d = S_BOX_D;
            end
            S_BOX_D: begin
                d_d     = (mode_q == 2'd0) ? root_ext - ONE : root_ext + smin(maxq, '0);
                psx_d   = px_q;
                psy_d   = py_q;
                psz_d   = pz_q;
                it_d    = '0;
                state_d = (k_q == '0) ? S_OUT : S_ITER_A;
            end
            S_ITER_A: begin
                rx_d    = fold(psx_q[FBITS:0]);
                ry_d    = fold(psy_q[FBITS:0]);
                rz_d    = fold(psz_q[FBITS:0]);
                state_d = S_ITER_B;
            end
            S_ITER_B: begin
                m_d     = smin(smin(smax(rx_q, ry_q), smax(ry_q, rz_q)), smax(rz_q, rx_q));
                state_d = S_ITER_C;
            end
            S_ITER_C: begin
                d_d     = smax(d_q, prod);
                psx_d   = psx_q + (psx_q <<< 1);
                psy_d   = psy_q + (psy_q <<< 1);
                psz_d   = psz_q + (psz_q <<< 1);
                it_d    = it_inc;
                state_d = (it_inc == k_q) ? S_OUT : S_ITER_A;
            end
            S_OUT: begin
                out_d   = (mode_q == 2'd3) ? MAXV : (d_q <<< shift_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
        mode_q  <= mode_d;   k_q   <= k_d;    it_q   <= it_d;   shift_q <= shift_d;
        px_q    <= px_d;     py_q  <= py_d;   pz_q   <= pz_d;
        qx_q    <= qx_d;     qy_q  <= qy_d;   qz_q   <= qz_d;
        psx_q   <= psx_d;    psy_q <= psy_d;  psz_q  <= psz_d;
        rx_q    <= rx_d;     ry_q  <= ry_d;   rz_q   <= rz_d;
        sum_q   <= sum_d;    d_q   <= d_d;    m_q    <= m_d;
        rad_q   <= rad_d;    rem_q <= rem_d;  root_q <= root_d;  cnt_q <= cnt_d;
    end

    assign busy     = busy_q;
    assign sdf_done = done_q;
    assign sdf_out  = out_q;
endmodule

// File: tb/tb_fractal_sdf.sv
// Scoreboard bench for fractal_sdf: requests push expected distance and done
// cycle; an independent monitor pops and compares on every sdf_done.
module tb_fractal_sdf;
  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic               sdf_start = 1'b0;
  logic [1:0]         mode = '0;
  logic [2:0]         iters = '0;
  logic [3:0]         scale_shift = '0;
  logic signed [31:0] x = '0, y = '0, z = '0;
  logic               busy, sdf_done;
  logic signed [31:0] sdf_out;

  fractal_sdf #(.WIDTH(32), .FBITS(16), .MAX_ITER(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sdf_start(sdf_start), .mode(mode),
    .iters(iters), .scale_shift(scale_shift), .x(x), .y(y), .z(z),
    .busy(busy), .sdf_done(sdf_done), .sdf_out(sdf_out)
  );

  initial forever #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] out;
    int          done_cyc;
  } exp_t;

  exp_t sb [32];
  int   wr_idx = 0;    // written by stimulus only
  int   rd_idx = 0;    // written by monitor only
  int   timeouts = 0;  // written by stimulus only
  bit   chk_rst = 1'b0, chk_end = 1'b0;

  int   checks = 0, errors = 0;
  bit   prev_done = 1'b0, busy_drop = 1'b0;
  exp_t e;

  always @(negedge clk_in) begin
    if (sdf_done === 1'b1) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_single_cycle: done high on consecutive cycles at cyc %0d", cyc);
      end
      if (rd_idx == wr_idx) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done with out=%h at cyc %0d, expected none", sdf_out, cyc);
      end else begin
        e = sb[rd_idx];
        rd_idx++;
        checks++;
        if (sdf_out !== e.out) begin
          errors++;
          $display("FAIL %s_out: got %h expected %h", e.name, sdf_out, e.out);
        end
        checks++;
        if (cyc != e.done_cyc) begin
          errors++;
          $display("FAIL %s_latency: done at cyc %0d expected cyc %0d", e.name, cyc, e.done_cyc);
        end
        checks++;
        if (busy !== 1'b1 || busy_drop) begin
          errors++;
          $display("FAIL %s_busy: busy=%b dropped=%b expected busy held 1", e.name, busy, busy_drop);
        end
      end
      busy_drop = 1'b0;
    end else if (rd_idx != wr_idx && busy !== 1'b1) begin
      busy_drop = 1'b1;
    end
    prev_done = (sdf_done === 1'b1);

    if (chk_rst) begin
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++;
      if (sdf_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", sdf_done); end
      checks++;
      if (sdf_out !== 32'h0) begin errors++; $display("FAIL rst_out: got %h expected 00000000", sdf_out); end
    end

    if (chk_end) begin
      checks++;
      if (rd_idx != wr_idx) begin
        errors++;
        $display("FAIL missing_results: got %0d results expected %0d", rd_idx, wr_idx);
      end
      checks++;
      if (timeouts != 0) begin
        errors++;
        $display("FAIL wait_timeouts: got %0d expected 0", timeouts);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input string nm, input logic [1:0] m, input logic [2:0] it,
                       input logic [3:0] sh, input logic [31:0] xx, input logic [31:0] yy,
                       input logic [31:0] zz, input logic [31:0] eo, input int lat,
                       input bit push, input bit poll);
    int n;
    int exp_cyc;
    n = 0;
    if (poll) begin
      while (busy !== 1'b0 && n < 300) begin
        tick();
        n++;
      end
      if (n >= 300) timeouts++;
    end
    mode = m; iters = it; scale_shift = sh;
    x = xx; y = yy; z = zz;
    sdf_start = 1'b1;
    exp_cyc = cyc + 1 + lat;
    tick();
    sdf_start = 1'b0;
    if (push) begin
      sb[wr_idx] = '{nm, eo, exp_cyc};
      wr_idx++;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sdf_done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) timeouts++;
  endtask

  initial begin
    tick();
    tick();
    chk_rst = 1'b1;
    tick();
    chk_rst = 1'b0;
    rst_in  = 1'b0;

    // Sphere, then an ignored start while busy, then a start in the first idle cycle.
    issue("sphere_2_0_0", 2'd0, 3'd0, 4'd0, 32'h0002_0000, 32'h0, 32'h0, 32'h0001_0000, 32, 1'b1, 1'b1);
    repeat (4) tick();
    issue("ignored", 2'd3, 3'd0, 4'd3, 32'h0005_0000, 32'h0001_0000, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    wait_done();
    tick();
    issue("box_origin", 2'd1, 3'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_0000, 32, 1'b1, 1'b0);

    issue("box_2_0_0",      2'd1, 3'd0, 4'd0, 32'h0002_0000, 32'h0,         32'h0,         32'h0001_0000, 32, 1'b1, 1'b1);
    issue("menger1_origin", 2'd2, 3'd1, 4'd0, 32'h0,         32'h0,         32'h0,         32'h0000_5555, 35, 1'b1, 1'b1);
    issue("menger7_clamp",  2'd2, 3'd7, 4'd0, 32'h0,         32'h0,         32'h0,         32'h0000_5555, 44, 1'b1, 1'b1);
    issue("menger1_half",   2'd2, 3'd1, 4'd0, 32'h0000_8000, 32'h0000_8000, 32'h0,         32'hFFFF_D555, 35, 1'b1, 1'b1);
    issue("menger2_half",   2'd2, 3'd2, 4'd0, 32'h0000_8000, 32'h0000_8000, 32'h0,         32'hFFFF_F1C7, 38, 1'b1, 1'b1);
    issue("menger1_neg",    2'd2, 3'd1, 4'd0, 32'hFFFF_8000, 32'hFFFF_8000, 32'h0,         32'hFFFF_D555, 35, 1'b1, 1'b1);
    issue("sphere_scale2",  2'd0, 3'd0, 4'd2, 32'h0008_0000, 32'h0,         32'h0,         32'h0004_0000, 32, 1'b1, 1'b1);
    issue("sphere_0_m3_4",  2'd0, 3'd0, 4'd0, 32'h0,         32'hFFFD_0000, 32'h0004_0000, 32'h0004_0000, 32, 1'b1, 1'b1);
    issue("box_m3_0_0",     2'd1, 3'd0, 4'd0, 32'hFFFD_0000, 32'h0,         32'h0,         32'h0002_0000, 32, 1'b1, 1'b1);
    issue("box_scale1",     2'd1, 3'd0, 4'd1, 32'h0,         32'h0,         32'h0,         32'hFFFE_0000, 32, 1'b1, 1'b1);
    issue("mode3",          2'd3, 3'd5, 4'd0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h7FFF_FFFF, 32, 1'b1, 1'b1);

    // Abort a sphere request during the root iterations; it must never report.
    issue("aborted", 2'd0, 3'd0, 4'd0, 32'h0002_0000, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b1);
    repeat (10) tick();
    rst_in = 1'b1;
    tick();
    rst_in  = 1'b0;
    chk_rst = 1'b1;
    tick();
    chk_rst = 1'b0;
    repeat (50) tick();

    issue("box_after_rst", 2'd1, 3'd0, 4'd0, 32'h0002_0000, 32'h0, 32'h0, 32'h0001_0000, 32, 1'b1, 1'b1);
    repeat (60) tick();
    chk_end = 1'b1;
    tick();
    chk_end = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
